// File: rtl/rv_ctl_mc2_if.sv
// Controller-side bundle: instruction/flag inputs, memory handshake and
// datapath control outputs, plus the retired-instruction count.
interface rv_ctl_mc2_if #(
  parameter int RET_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic             memreq;
  logic             memrw;
  logic             pcsource;
  logic             pcwrite;
  logic             pccen;
  logic             irwrite;
  logic [1:0]       wbsel;
  logic             regwen;
  logic [1:0]       immsel;
  logic             asel;
  logic             bsel;
  logic [3:0]       alusel;
  logic             mdrwrite;
  logic             illegal;
  logic             halted;
  logic [RET_W-1:0] retired;

  modport master (
    input  instr, zero, mem_ready,
    output memreq, memrw, pcsource, pcwrite, pccen, irwrite, wbsel, regwen,
           immsel, asel, bsel, alusel, mdrwrite, illegal, halted, retired
  );

  modport slave (
    output instr, zero, mem_ready,
    input  memreq, memrw, pcsource, pcwrite, pccen, irwrite, wbsel, regwen,
           immsel, asel, bsel, alusel, mdrwrite, illegal, halted, retired
  );
endinterface

// File: rtl/rv_ctl_mc2.sv
// Multicycle RISC-V control FSM with I-ALU, optional BNE, memory wait states,
// illegal-instruction trap and a retired-instruction counter.
//
// state       | meaning
// ------------+--------------------------------------------------
// FETCH       | request instruction, load IR and PC+4 when ready
// DECODE      | classify instruction, precompute branch target
// LSW_ADDR    | effective address for load/store
// LW_MEM      | load access, MDR captures data when ready
// LW_WB       | write MDR to register file
// SW_MEM      | store access, held until ready
// RTYPE_ALU   | register/register ALU op
// ITYPE_ALU   | register/immediate ALU op
// ALU_WB      | write ALU result to register file
// BR_EXEC     | compare operands, take branch via PC_ALU
// JAL_EXEC    | link PC and jump
// TRAP        | illegal instruction, halted until reset
module rv_ctl_mc2 #(
  parameter bit SUPPORT_BNE     = 1'b1,
  parameter bit MEM_WAIT_EN     = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int RET_W           = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  rv_ctl_mc2_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_LSW_ADDR  = 4'd2,
    S_LW_MEM    = 4'd3,
    S_LW_WB     = 4'd4,
    S_SW_MEM    = 4'd5,
    S_RTYPE_ALU = 4'd6,
    S_ITYPE_ALU = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BR_EXEC   = 4'd9,
    S_JAL_EXEC  = 4'd10,
    S_TRAP      = 4'd11
  } state_t;

  localparam logic       PC_INC    = 1'b0;
  localparam logic       PC_ALU    = 1'b1;
  localparam logic [1:0] WB_PC     = 2'd0;
  localparam logic [1:0] WB_ALUOUT = 2'd1;
  localparam logic [1:0] WB_MDR    = 2'd2;
  localparam logic [1:0] IMM_I     = 2'd0;
  localparam logic [1:0] IMM_S     = 2'd1;
  localparam logic [1:0] IMM_B     = 2'd2;
  localparam logic [1:0] IMM_J     = 2'd3;
  localparam logic       ALUA_REG  = 1'b0;
  localparam logic       ALUA_PCC  = 1'b1;
  localparam logic       ALUB_REG  = 1'b0;
  localparam logic       ALUB_IMM  = 1'b1;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;

  state_t           state_q, state_d;
  logic [RET_W-1:0] ret_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_lw, is_sw, is_r, is_i, is_beq, is_bne, is_jal;
  logic       ready;
  logic       retire;

  logic       memreq_c, memrw_c, pcsource_c, pcwrite_c, pccen_c, irwrite_c;
  logic [1:0] wbsel_c, immsel_c;
  logic       regwen_c, asel_c, bsel_c, mdrwrite_c, illegal_c, halted_c;
  logic [3:0] alusel_c;

  logic       unused_instr;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];

  assign is_lw  = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw  = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011) &&
                  ((funct3 == 3'b000) || (funct3 == 3'b100) ||
                   (funct3 == 3'b110) || (funct3 == 3'b111));
  assign is_beq = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_bne = SUPPORT_BNE && (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_jal = (opcode == 7'b1101111);

  assign ready  = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ret_q <= '0;
    else if (retire) ret_q <= ret_q + {{(RET_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_lw || is_sw)        state_d = S_LSW_ADDR;
        else if (is_r)             state_d = S_RTYPE_ALU;
        else if (is_i)             state_d = S_ITYPE_ALU;
        else if (is_beq || is_bne) state_d = S_BR_EXEC;
        else if (is_jal)           state_d = S_JAL_EXEC;
        else if (TRAP_ON_ILLEGAL)  state_d = S_TRAP;
        else                       state_d = S_FETCH;
      end
      S_LSW_ADDR:  state_d = is_sw ? S_SW_MEM : S_LW_MEM;
      S_LW_MEM:    if (ready) state_d = S_LW_WB;
      S_LW_WB:     state_d = S_FETCH;
      S_SW_MEM:    if (ready) state_d = S_FETCH;
      S_RTYPE_ALU: state_d = S_ALU_WB;
      S_ITYPE_ALU: state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BR_EXEC:   state_d = S_FETCH;
      S_JAL_EXEC:  state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // Outputs sit at their defaults while reset is asserted, even though the
  // register already reads FETCH.
  always_comb begin
    memreq_c   = 1'b0;
    memrw_c    = 1'b0;
    pcsource_c = PC_INC;
    pcwrite_c  = 1'b0;
    pccen_c    = 1'b0;
    irwrite_c  = 1'b0;
    wbsel_c    = WB_PC;
    regwen_c   = 1'b0;
    immsel_c   = IMM_B;
    asel_c     = ALUA_REG;
    bsel_c     = ALUB_REG;
    alusel_c   = ALU_ADD;
    mdrwrite_c = 1'b0;
    illegal_c  = 1'b0;
    halted_c   = 1'b0;
    retire     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          memreq_c  = 1'b1;
          pccen_c   = ready;
          pcwrite_c = ready;
          irwrite_c = ready;
        end
        S_DECODE: begin
          immsel_c = IMM_B;
          asel_c   = ALUA_PCC;
          bsel_c   = ALUB_IMM;
          if (!(is_lw || is_sw || is_r || is_i || is_beq || is_bne || is_jal) &&
              !TRAP_ON_ILLEGAL)
            illegal_c = 1'b1;
        end
        S_LSW_ADDR: begin
          immsel_c = is_sw ? IMM_S : IMM_I;
          bsel_c   = ALUB_IMM;
        end
        S_LW_MEM: begin
          memreq_c   = 1'b1;
          mdrwrite_c = ready;
        end
        S_LW_WB: begin
          wbsel_c  = WB_MDR;
          regwen_c = 1'b1;
          retire   = 1'b1;
        end
        S_SW_MEM: begin
          memreq_c = 1'b1;
          memrw_c  = 1'b1;
          retire   = ready;
        end
        S_RTYPE_ALU: alusel_c = {funct3, bus.instr[30]};
        S_ITYPE_ALU: begin
          immsel_c = IMM_I;
          bsel_c   = ALUB_IMM;
          alusel_c = {funct3, 1'b0};
        end
        S_ALU_WB: begin
          wbsel_c  = WB_ALUOUT;
          regwen_c = 1'b1;
          retire   = 1'b1;
        end
        S_BR_EXEC: begin
          alusel_c   = ALU_SUB;
          pcsource_c = PC_ALU;
          pcwrite_c  = bus.instr[12] ? ~bus.zero : bus.zero;
          retire     = 1'b1;
        end
        S_JAL_EXEC: begin
          immsel_c   = IMM_J;
          asel_c     = ALUA_PCC;
          bsel_c     = ALUB_IMM;
          pcsource_c = PC_ALU;
          pcwrite_c  = 1'b1;
          regwen_c   = 1'b1;
          wbsel_c    = WB_PC;
          retire     = 1'b1;
        end
        S_TRAP: begin
          illegal_c = 1'b1;
          halted_c  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.memreq   = memreq_c;
  assign bus.memrw    = memrw_c;
  assign bus.pcsource = pcsource_c;
  assign bus.pcwrite  = pcwrite_c;
  assign bus.pccen    = pccen_c;
  assign bus.irwrite  = irwrite_c;
  assign bus.wbsel    = wbsel_c;
  assign bus.regwen   = regwen_c;
  assign bus.immsel   = immsel_c;
  assign bus.asel     = asel_c;
  assign bus.bsel     = bsel_c;
  assign bus.alusel   = alusel_c;
  assign bus.mdrwrite = mdrwrite_c;
  assign bus.illegal  = illegal_c;
  assign bus.halted   = halted_c;
  assign bus.retired  = ret_q;

endmodule

// File: tb/tb_rv_ctl_mc2.sv
// Directed bench: default controller plus a no-BNE / no-wait / no-trap / 2-bit
// counter variant, checked cycle by cycle against hand-built control vectors.
module tb_rv_ctl_mc2;

  logic clk;
  logic rst_a, rst_b;
  int   n_chk = 0;
  int   n_err = 0;

  rv_ctl_mc2_if #(.RET_W(32)) bus_a ();
  rv_ctl_mc2_if #(.RET_W(2))  bus_b ();

  rv_ctl_mc2 #(
    .SUPPORT_BNE(1'b1), .MEM_WAIT_EN(1'b1), .TRAP_ON_ILLEGAL(1'b1), .RET_W(32)
  ) u_a (.clk(clk), .rst_n(rst_a), .bus(bus_a.master));

  rv_ctl_mc2 #(
    .SUPPORT_BNE(1'b0), .MEM_WAIT_EN(1'b0), .TRAP_ON_ILLEGAL(1'b0), .RET_W(2)
  ) u_b (.clk(clk), .rst_n(rst_b), .bus(bus_b.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {memreq,memrw,pcsource,pcwrite,pccen,irwrite,wbsel,regwen,immsel,asel,bsel,alusel,mdrwrite,illegal,halted}
  logic [19:0] ctl_a, ctl_b;
  assign ctl_a = {bus_a.memreq, bus_a.memrw, bus_a.pcsource, bus_a.pcwrite, bus_a.pccen,
                  bus_a.irwrite, bus_a.wbsel, bus_a.regwen, bus_a.immsel, bus_a.asel,
                  bus_a.bsel, bus_a.alusel, bus_a.mdrwrite, bus_a.illegal, bus_a.halted};
  assign ctl_b = {bus_b.memreq, bus_b.memrw, bus_b.pcsource, bus_b.pcwrite, bus_b.pccen,
                  bus_b.irwrite, bus_b.wbsel, bus_b.regwen, bus_b.immsel, bus_b.asel,
                  bus_b.bsel, bus_b.alusel, bus_b.mdrwrite, bus_b.illegal, bus_b.halted};

  localparam logic [19:0] C_DEF   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_FWAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_FRDY  = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,2'd0,1'b0,2'd2,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd2,1'b1,1'b1,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_DECIL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd2,1'b1,1'b1,4'h0,1'b0,1'b1,1'b0};
  localparam logic [19:0] C_ITYPE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,1'b0,1'b1,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_RSUB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,4'h1,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_ALUWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,1'b1,2'd2,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_LSW_S = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd1,1'b0,1'b1,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_LSW_L = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,1'b0,1'b1,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_SWMEM = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_LWWT  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_LWRDY = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,4'h0,1'b1,1'b0,1'b0};
  localparam logic [19:0] C_LWWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,1'b1,2'd2,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_BR1   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,4'h1,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_BR0   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,4'h1,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_JAL   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,1'b1,2'd3,1'b1,1'b1,4'h0,1'b0,1'b0,1'b0};
  localparam logic [19:0] C_TRAP  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,4'h0,1'b0,1'b1,1'b1};

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_SUB  = 32'h4000_0033;
  localparam logic [31:0] I_SW   = 32'h0010_2023;
  localparam logic [31:0] I_LW   = 32'h0000_2083;
  localparam logic [31:0] I_BNE  = 32'h0000_1063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input string tag, input logic [19:0] exp);
    #1;
    chk(tag, {12'd0, ctl_a}, {12'd0, exp});
    tick();
  endtask

  task automatic step_b(input string tag, input logic [19:0] exp);
    #1;
    chk(tag, {12'd0, ctl_b}, {12'd0, exp});
    tick();
  endtask

  logic [1:0] exp_b;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.instr = 32'd0; bus_a.zero = 1'b0; bus_a.mem_ready = 1'b0;
    bus_b.instr = 32'd0; bus_b.zero = 1'b0; bus_b.mem_ready = 1'b0;
    tick();
    chk("a_rst_ctl", {12'd0, ctl_a}, {12'd0, C_DEF});
    chk("a_rst_ret", bus_a.retired, 32'd0);
    chk("b_rst_ctl", {12'd0, ctl_b}, {12'd0, C_DEF});
    chk("b_rst_ret", {30'd0, bus_b.retired}, 32'd0);
    tick();
    rst_a = 1'b1;

    // fetch waits three cycles, then ADDI
    bus_a.instr = I_ADDI;
    for (int i = 0; i < 3; i++) step_a("a_fetch_wait", C_FWAIT);
    bus_a.mem_ready = 1'b1;
    step_a("a_fetch_rdy", C_FRDY);
    step_a("a_addi_dec", C_DEC);
    step_a("a_addi_itype", C_ITYPE);
    chk("a_ret_before_wb", bus_a.retired, 32'd0);
    step_a("a_addi_wb", C_ALUWB);
    chk("a_ret_addi", bus_a.retired, 32'd1);

    bus_a.instr = I_SUB;
    step_a("a_sub_fetch", C_FRDY);
    step_a("a_sub_dec", C_DEC);
    step_a("a_sub_rtype", C_RSUB);
    step_a("a_sub_wb", C_ALUWB);
    chk("a_ret_sub", bus_a.retired, 32'd2);

    // store held two wait cycles
    bus_a.instr = I_SW;
    step_a("a_sw_fetch", C_FRDY);
    step_a("a_sw_dec", C_DEC);
    step_a("a_sw_addr", C_LSW_S);
    bus_a.mem_ready = 1'b0;
    step_a("a_sw_mem0", C_SWMEM);
    chk("a_ret_sw_wait0", bus_a.retired, 32'd2);
    step_a("a_sw_mem1", C_SWMEM);
    chk("a_ret_sw_wait1", bus_a.retired, 32'd2);
    bus_a.mem_ready = 1'b1;
    step_a("a_sw_mem2", C_SWMEM);
    chk("a_ret_sw", bus_a.retired, 32'd3);

    bus_a.instr = I_BNE; bus_a.zero = 1'b0;
    step_a("a_bne0_fetch", C_FRDY);
    step_a("a_bne0_dec", C_DEC);
    step_a("a_bne0_exec", C_BR1);
    chk("a_ret_bne0", bus_a.retired, 32'd4);
    bus_a.zero = 1'b1;
    step_a("a_bne1_fetch", C_FRDY);
    step_a("a_bne1_dec", C_DEC);
    step_a("a_bne1_exec", C_BR0);
    chk("a_ret_bne1", bus_a.retired, 32'd5);

    bus_a.instr = I_JAL;
    step_a("a_jal_fetch", C_FRDY);
    step_a("a_jal_dec", C_DEC);
    step_a("a_jal_exec", C_JAL);
    chk("a_ret_jal", bus_a.retired, 32'd6);

    // reset in the middle of a load
    bus_a.instr = I_LW;
    step_a("a_lw_fetch", C_FRDY);
    step_a("a_lw_dec", C_DEC);
    step_a("a_lw_addr", C_LSW_L);
    bus_a.mem_ready = 1'b0;
    step_a("a_lw_wait", C_LWWT);
    chk("a_ret_lw_wait", bus_a.retired, 32'd6);
    #3;
    rst_a = 1'b0;
    #1;
    chk("a_midrst_ctl", {12'd0, ctl_a}, {12'd0, C_DEF});
    chk("a_midrst_ret", bus_a.retired, 32'd0);
    tick();
    rst_a = 1'b1;
    step_a("a_post_rst_fetch", C_FWAIT);
    bus_a.mem_ready = 1'b1;
    step_a("a_lw2_fetch", C_FRDY);
    step_a("a_lw2_dec", C_DEC);
    step_a("a_lw2_addr", C_LSW_L);
    step_a("a_lw2_mem", C_LWRDY);
    step_a("a_lw2_wb", C_LWWB);
    chk("a_ret_lw2", bus_a.retired, 32'd1);

    bus_a.instr = I_BAD;
    step_a("a_bad_fetch", C_FRDY);
    step_a("a_bad_dec", C_DEC);
    for (int i = 0; i < 4; i++) step_a("a_trap", C_TRAP);
    chk("a_ret_trap", bus_a.retired, 32'd1);

    // variant: BNE illegal, no wait states, no trap, 2-bit counter
    rst_b = 1'b1;
    bus_b.instr = I_BNE;
    step_b("b_bne_fetch", C_FRDY);
    step_b("b_bne_dec", C_DECIL);
    bus_b.instr = I_BAD;
    step_b("b_bad_fetch", C_FRDY);
    step_b("b_bad_dec", C_DECIL);
    chk("b_ret_illegal", {30'd0, bus_b.retired}, 32'd0);
    bus_b.instr = I_ADDI;
    for (int i = 0; i < 4; i++) begin
      step_b("b_addi_fetch", C_FRDY);
      step_b("b_addi_dec", C_DEC);
      step_b("b_addi_itype", C_ITYPE);
      step_b("b_addi_wb", C_ALUWB);
      exp_b = 2'(i + 1);
      chk("b_ret_addi", {30'd0, bus_b.retired}, {30'd0, exp_b});
    end
    bus_b.instr = I_LW;
    step_b("b_lw_fetch", C_FRDY);
    step_b("b_lw_dec", C_DEC);
    step_b("b_lw_addr", C_LSW_L);
    step_b("b_lw_mem", C_LWRDY);
    step_b("b_lw_wb", C_LWWB);
    chk("b_ret_wrap", {30'd0, bus_b.retired}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
